// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the basic computer control path: bus selects, ALU ops,
// opcodes and sequence-counter sizing.
package basic_computer_pkg;

    localparam int WIDTH    = 16;
    localparam int T_STATES = 16;
    localparam int SC_W     = $clog2(T_STATES);
    localparam int SC_LAST  = 6;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_AR   = 3'd1,
        SEL_PC   = 3'd2,
        SEL_DR   = 3'd3,
        SEL_AC   = 3'd4,
        SEL_IR   = 3'd5,
        SEL_TR   = 3'd6,
        SEL_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [1:0] {
        ALU_NONE = 2'b00,
        ALU_AND  = 2'b01,
        ALU_ADD  = 2'b10,
        ALU_XFER = 2'b11
    } alu_op_e;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath signal bundle. fgi/fgo exist only when INTERRUPT_EN is defined.
interface control_sequencer_if;
    import basic_computer_pkg::*;

    logic [WIDTH-1:0] ir;
    logic             dr_zero;
    logic             ac_zero;
    logic             ac_sign;
    logic             e_zero;
`ifdef INTERRUPT_EN
    logic             fgi;
    logic             fgo;
`endif
    logic [2:0]       bus_selects;
    logic             ld_ar, inr_ar, clr_ar;
    logic             ld_pc, inr_pc, clr_pc;
    logic             ld_dr, inr_dr, ld_ac, ld_ir, ld_tr;
    logic             mem_write;
    logic [1:0]       alu_op;
    logic             exec_rr, exec_io, halted;

    modport master (
`ifdef INTERRUPT_EN
        input  fgi, fgo,
`endif
        input  ir, dr_zero, ac_zero, ac_sign, e_zero,
        output bus_selects, ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc,
        output ld_dr, inr_dr, ld_ac, ld_ir, ld_tr, mem_write, alu_op,
        output exec_rr, exec_io, halted
    );

    modport slave (
`ifdef INTERRUPT_EN
        output fgi, fgo,
`endif
        output ir, dr_zero, ac_zero, ac_sign, e_zero,
        input  bus_selects, ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc,
        input  ld_dr, inr_dr, ld_ac, ld_ir, ld_tr, mem_write, alu_op,
        input  exec_rr, exec_io, halted
    );

endinterface

// File: rtl/control_sequencer_sequence_counter.sv
// T-state counter: hold has priority over clear, clear over increment.
module sequence_counter
    import basic_computer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    input  logic            hold,
    output logic [SC_W-1:0] sc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc <= '0;
        end else if (!hold) begin
            if (clr)
                sc <= '0;
            else if (inc)
                sc <= sc + 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Timing and control unit: T-state sequencing and strobe decode for fetch, indirect,
// memory-reference and register/IO execution. INTERRUPT_EN adds the interrupt cycle.
module control_sequencer
    import basic_computer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master cs
);

    logic [SC_W-1:0] sc;
    logic            started_reg, halted_reg, i_flag_reg;
    logic            active, sc_clr, set_halt, load_iflag, rr_skip, sc_past_fetch;
    logic [2:0]      opcode;
    logic            unused_ir;
`ifdef INTERRUPT_EN
    logic            r_reg, ien_reg, ien_set, ien_clr, irq_done;
`endif

    assign active        = started_reg & ~halted_reg;
    assign opcode        = cs.ir[14:12];
    assign sc_past_fetch = int'(sc) > 2;
    assign unused_ir     = ^cs.ir[11:5];
    assign rr_skip = (cs.ir[4] & ~cs.ac_sign & ~cs.ac_zero) | (cs.ir[3] & cs.ac_sign) |
                     (cs.ir[2] & cs.ac_zero) | (cs.ir[1] & cs.e_zero);

    sequence_counter u_sc (
        .clk  (clk),
        .rst  (rst),
        .inc  (active & ~sc_clr),
        .clr  (sc_clr),
        .hold (~active),
        .sc   (sc)
    );

    always_comb begin
        cs.bus_selects = SEL_NONE;
        cs.ld_ar = 1'b0;  cs.inr_ar = 1'b0;  cs.clr_ar = 1'b0;
        cs.ld_pc = 1'b0;  cs.inr_pc = 1'b0;  cs.clr_pc = 1'b0;
        cs.ld_dr = 1'b0;  cs.inr_dr = 1'b0;  cs.ld_ac  = 1'b0;
        cs.ld_ir = 1'b0;  cs.ld_tr  = 1'b0;  cs.mem_write = 1'b0;
        cs.alu_op  = ALU_NONE;
        cs.exec_rr = 1'b0;
        cs.exec_io = 1'b0;
        cs.halted  = halted_reg;
        sc_clr     = 1'b0;
        set_halt   = 1'b0;
        load_iflag = 1'b0;
`ifdef INTERRUPT_EN
        ien_set  = 1'b0;
        ien_clr  = 1'b0;
        irq_done = 1'b0;
`endif
        if (!active) begin
            // idle before the first edge after reset, and permanently once halted
        end
`ifdef INTERRUPT_EN
        else if (r_reg && !sc_past_fetch) begin
            case (int'(sc))
                0: begin cs.clr_ar = 1'b1; cs.bus_selects = SEL_PC; cs.ld_tr = 1'b1; end
                1: begin cs.bus_selects = SEL_TR; cs.mem_write = 1'b1; cs.clr_pc = 1'b1; end
                default: begin cs.inr_pc = 1'b1; irq_done = 1'b1; sc_clr = 1'b1; end
            endcase
        end
`endif
        else begin
            case (int'(sc))
                0: begin cs.bus_selects = SEL_PC;  cs.ld_ar = 1'b1; end
                1: begin cs.bus_selects = SEL_MEM; cs.ld_ir = 1'b1; cs.inr_pc = 1'b1; end
                2: begin cs.bus_selects = SEL_IR;  cs.ld_ar = 1'b1; load_iflag = 1'b1; end
                3: begin
                    if (opcode == OP_REG) begin
                        sc_clr = 1'b1;
                        if (cs.ir[WIDTH-1]) begin
                            cs.exec_io = 1'b1;
`ifdef INTERRUPT_EN
                            cs.inr_pc = (cs.ir[9] & cs.fgi) | (cs.ir[8] & cs.fgo);
                            ien_set   = cs.ir[7];
                            ien_clr   = cs.ir[6];
`endif
                        end else begin
                            cs.exec_rr = 1'b1;
                            cs.inr_pc  = rr_skip;
                            set_halt   = cs.ir[0];
                        end
                    end else if (i_flag_reg) begin
                        cs.bus_selects = SEL_MEM;
                        cs.ld_ar       = 1'b1;
                    end
                end
                4: begin
                    case (opcode)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            cs.bus_selects = SEL_MEM; cs.ld_dr = 1'b1;
                        end
                        OP_STA: begin cs.bus_selects = SEL_AC; cs.mem_write = 1'b1; sc_clr = 1'b1; end
                        OP_BUN: begin cs.bus_selects = SEL_AR; cs.ld_pc = 1'b1; sc_clr = 1'b1; end
                        OP_BSA: begin cs.bus_selects = SEL_PC; cs.mem_write = 1'b1; cs.inr_ar = 1'b1; end
                        default: ;
                    endcase
                end
                5: begin
                    case (opcode)
                        OP_AND: begin cs.ld_ac = 1'b1; cs.alu_op = ALU_AND;  sc_clr = 1'b1; end
                        OP_ADD: begin cs.ld_ac = 1'b1; cs.alu_op = ALU_ADD;  sc_clr = 1'b1; end
                        OP_LDA: begin cs.ld_ac = 1'b1; cs.alu_op = ALU_XFER; sc_clr = 1'b1; end
                        OP_BSA: begin cs.bus_selects = SEL_AR; cs.ld_pc = 1'b1; sc_clr = 1'b1; end
                        OP_ISZ: cs.inr_dr = 1'b1;
                        default: ;
                    endcase
                end
                SC_LAST: begin
                    if (opcode == OP_ISZ) begin
                        cs.bus_selects = SEL_DR;
                        cs.mem_write   = 1'b1;
                        cs.inr_pc      = cs.dr_zero;
                    end
                    sc_clr = 1'b1;
                end
                // 7..15 cannot be reached; recover to T0 rather than wander
                default: sc_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_reg <= 1'b0;
            halted_reg  <= 1'b0;
            i_flag_reg  <= 1'b0;
`ifdef INTERRUPT_EN
            r_reg       <= 1'b0;
            ien_reg     <= 1'b0;
`endif
        end else begin
            started_reg <= 1'b1;
            if (load_iflag)
                i_flag_reg <= cs.ir[WIDTH-1];
            if (set_halt)
                halted_reg <= 1'b1;
`ifdef INTERRUPT_EN
            if (irq_done) begin
                r_reg   <= 1'b0;
                ien_reg <= 1'b0;
            end else begin
                if (active && sc_past_fetch && ien_reg && (cs.fgi | cs.fgo))
                    r_reg <= 1'b1;
                if (ien_set)
                    ien_reg <= 1'b1;
                else if (ien_clr)
                    ien_reg <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver queues the expected strobe
// vector for each cycle, the monitor pops and compares on the falling edge.
module tb_control_sequencer;

    localparam logic [19:0] LD_AR   = 20'h10000;
    localparam logic [19:0] INR_AR  = 20'h08000;
    localparam logic [19:0] CLR_AR  = 20'h04000;
    localparam logic [19:0] LD_PC   = 20'h02000;
    localparam logic [19:0] INR_PC  = 20'h01000;
    localparam logic [19:0] CLR_PC  = 20'h00800;
    localparam logic [19:0] LD_DR   = 20'h00400;
    localparam logic [19:0] INR_DR  = 20'h00200;
    localparam logic [19:0] LD_AC   = 20'h00100;
    localparam logic [19:0] LD_IR   = 20'h00080;
    localparam logic [19:0] LD_TR   = 20'h00040;
    localparam logic [19:0] MEM_WR  = 20'h00020;
    localparam logic [19:0] A_AND   = 20'h00008;
    localparam logic [19:0] A_ADD   = 20'h00010;
    localparam logic [19:0] A_DR    = 20'h00018;
    localparam logic [19:0] EXEC_RR = 20'h00004;
    localparam logic [19:0] EXEC_IO = 20'h00002;
    localparam logic [19:0] HALTED  = 20'h00001;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [19:0] act;
    logic [19:0] exp_v;
    string       exp_n;
    logic [19:0] exp_q[$];
    string       nm_q[$];

    control_sequencer_if vif();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .cs  (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {vif.bus_selects, vif.ld_ar, vif.inr_ar, vif.clr_ar, vif.ld_pc, vif.inr_pc,
                  vif.clr_pc, vif.ld_dr, vif.inr_dr, vif.ld_ac, vif.ld_ir, vif.ld_tr,
                  vif.mem_write, vif.alu_op, vif.exec_rr, vif.exec_io, vif.halted};

    function automatic logic [19:0] bs(input logic [2:0] b);
        return {b, 17'b0};
    endfunction

    task automatic cyc(input logic [15:0] irv, input logic [19:0] ev, input string nm);
        vif.ir = irv;
        exp_q.push_back(ev);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] irv, input string nm);
        cyc(irv, bs(3'd2) | LD_AR, {nm, " T0"});
        cyc(irv, bs(3'd7) | LD_IR | INR_PC, {nm, " T1"});
        cyc(irv, bs(3'd5) | LD_AR, {nm, " T2"});
    endtask

    task automatic do_reset(input logic [15:0] irv);
        rst = 1'b1;
        cyc(irv, 20'h0, "reset held");
        rst = 1'b0;
        cyc(irv, 20'h0, "first clock after release");
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            exp_n = nm_q.pop_front();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", exp_n, act, exp_v);
            end else begin
                $display("ok   %s: %05h", exp_n, act);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        vif.ir = 16'h0;
        vif.dr_zero = 1'b0;
        vif.ac_zero = 1'b0;
        vif.ac_sign = 1'b0;
        vif.e_zero  = 1'b0;
`ifdef INTERRUPT_EN
        vif.fgi = 1'b0;
        vif.fgo = 1'b0;
`endif
        @(posedge clk);
        #1;

        // HLT
        do_reset(16'h7001);
        fetch(16'h7001, "hlt");
        cyc(16'h7001, EXEC_RR, "hlt T3");
        for (int i = 0; i < 3; i++) cyc(16'h7001, HALTED, "halted idle");

        // LDA direct, then back-to-back instructions
        do_reset(16'h2123);
        fetch(16'h2123, "lda");
        cyc(16'h2123, 20'h0, "lda T3 direct");
        cyc(16'h2123, bs(3'd7) | LD_DR, "lda T4");
        cyc(16'h2123, LD_AC | A_DR, "lda T5");

        fetch(16'h9123, "add-ind");
        cyc(16'h9123, bs(3'd7) | LD_AR, "add T3 indirect");
        cyc(16'h9123, bs(3'd7) | LD_DR, "add T4");
        cyc(16'h9123, LD_AC | A_ADD, "add T5");

        fetch(16'h0123, "and");
        cyc(16'h0123, 20'h0, "and T3 direct");
        cyc(16'h0123, bs(3'd7) | LD_DR, "and T4");
        cyc(16'h0123, LD_AC | A_AND, "and T5");

        fetch(16'h3123, "sta");
        cyc(16'h3123, 20'h0, "sta T3");
        cyc(16'h3123, bs(3'd4) | MEM_WR, "sta T4");

        fetch(16'h4123, "bun");
        cyc(16'h4123, 20'h0, "bun T3");
        cyc(16'h4123, bs(3'd1) | LD_PC, "bun T4");

        fetch(16'h5123, "bsa");
        cyc(16'h5123, 20'h0, "bsa T3");
        cyc(16'h5123, bs(3'd2) | MEM_WR | INR_AR, "bsa T4");
        cyc(16'h5123, bs(3'd1) | LD_PC, "bsa T5");

        vif.dr_zero = 1'b1;
        fetch(16'h6040, "isz dz=1");
        cyc(16'h6040, 20'h0, "isz T3");
        cyc(16'h6040, bs(3'd7) | LD_DR, "isz T4");
        cyc(16'h6040, INR_DR, "isz T5");
        cyc(16'h6040, bs(3'd3) | MEM_WR | INR_PC, "isz T6 dr_zero=1");
        vif.dr_zero = 1'b0;
        fetch(16'h6040, "isz dz=0");
        cyc(16'h6040, 20'h0, "isz T3");
        cyc(16'h6040, bs(3'd7) | LD_DR, "isz T4");
        cyc(16'h6040, INR_DR, "isz T5");
        cyc(16'h6040, bs(3'd3) | MEM_WR, "isz T6 dr_zero=0");

        vif.ac_zero = 1'b1;
        fetch(16'h7004, "sza az=1");
        cyc(16'h7004, EXEC_RR | INR_PC, "sza T3 skip");
        vif.ac_zero = 1'b0;
        fetch(16'h7004, "sza az=0");
        cyc(16'h7004, EXEC_RR, "sza T3 no skip");

        fetch(16'hF080, "ion");
        cyc(16'hF080, EXEC_IO, "ion T3");

`ifdef INTERRUPT_EN
        fetch(16'h2123, "lda irq");
        cyc(16'h2123, 20'h0, "lda irq T3");
        vif.fgi = 1'b1;
        cyc(16'h2123, bs(3'd7) | LD_DR, "lda irq T4");
        cyc(16'h2123, LD_AC | A_DR, "lda irq T5");
        cyc(16'h2123, bs(3'd2) | CLR_AR | LD_TR, "RT0");
        cyc(16'h2123, bs(3'd6) | MEM_WR | CLR_PC, "RT1");
        cyc(16'h2123, INR_PC, "RT2");
        fetch(16'h2123, "lda ien=0");
        cyc(16'h2123, 20'h0, "lda ien=0 T3");
        cyc(16'h2123, bs(3'd7) | LD_DR, "lda ien=0 T4");
        cyc(16'h2123, LD_AC | A_DR, "lda ien=0 T5");
        fetch(16'hF200, "ski fgi=1");
        cyc(16'hF200, EXEC_IO | INR_PC, "ski T3 skip");
        vif.fgi = 1'b0;
`endif

        // reset mid-ISZ
        fetch(16'h6040, "isz abort");
        cyc(16'h6040, 20'h0, "isz abort T3");
        cyc(16'h6040, bs(3'd7) | LD_DR, "isz abort T4");
        rst = 1'b1;
        cyc(16'h6040, 20'h0, "reset at isz T5");
        rst = 1'b0;
        cyc(16'h6040, 20'h0, "first clock after release");
        fetch(16'h6040, "restart");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
